dijkstra_relax_unit: RTL and testbench
======================================

Name: dijkstra_relax_unit

Overview:
- Parametrised multi-cycle Nios II custom-instruction unit that performs a full Dijkstra edge relaxation in hardware.
- Candidate distance is dist_u + weight (IEEE-754 single). It is compared against a held dist_v, and the minimum is both kept and returned.
- Selected by the custom-instruction extension field n: LOAD, RELAX, STATUS and CLEAR.
- Sits on the CPU custom-instruction port next to the path-finding software loop. It wraps the team's fp_add core.

Parameters:
- ADD_LATENCY, 2, pipeline depth in cycles of the fp_add instance (range 1..8).
- INF_VALUE, 32'h7F800000, encoding used for "unreachable".
- CNT_WIDTH, 31, width of the relaxation counter (optional feature only; range 1..31).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  clock enable; when low, all state is frozen, including the fp_add enable
- start  in  1  single-cycle strobe that begins an operation
- n  in  2  opcode: 0 LOAD, 1 RELAX, 2 STATUS, 3 CLEAR
- dataa  in  32  LOAD: new dist_v; RELAX: dist_u
- datab  in  32  RELAX: edge weight; ignored otherwise
- done  out  1  one-cycle completion pulse, registered
- result  out  32  operation result, valid only while done=1, registered

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: done=0, result=0, dist_v_reg=INF_VALUE, improved=0, counter=0, FSM=IDLE. Reset overrides clk_en.
- Reset asserted mid-operation aborts the operation. No done is emitted for it. Any adder result still in flight is discarded.
- All sequential updates happen only when clk_en=1. Latency is counted in enabled cycles.
- FSM states:
  - IDLE: sample start. dataa, datab and n are captured into operand registers on the start cycle.
  - ADD_WAIT: count ADD_LATENCY+1 enabled cycles.
  - RESP: done=1 for exactly one cycle, then return to IDLE.
- start while not IDLE is ignored; no queueing. start with clk_en=0 is ignored.
- LOAD, STATUS, CLEAR and RELAX fast paths go IDLE->RESP, so done is high on cycle start+1.
- LOAD: dist_v_reg<=dataa; result=dataa; improved unchanged.
- STATUS: result={31'b0, improved}. Bits [31:1] change only with the optional feature.
- CLEAR: dist_v_reg<=INF_VALUE, improved<=0, counter<=0; result=0.
- RELAX fast path: candidate=INF_VALUE, with no adder use, when any of the following holds:
  - dataa exponent is all ones (INF or NaN);
  - datab exponent is all ones;
  - datab[31]=1 (any negative value, including -0);
  - datab[30:0]=0 (+0).
- RELAX normal path:
  - Adder inputs are driven from the operand registers; sum is valid ADD_LATENCY cycles after capture.
  - done is high on cycle start+ADD_LATENCY+2.
  - A sum that overflows to INF, or is NaN, is forced to INF_VALUE.
- RELAX compare:
  - Both values are non-negative, so compare as unsigned on bits [30:0].
  - If candidate < dist_v_reg: result=candidate, dist_v_reg<=candidate, improved<=1.
  - Otherwise (including equal): result=dist_v_reg, improved<=0.
  - Each completed RELAX (fast or normal path) increments counter when the feature is enabled.
- dataa and datab may change after the start cycle without affecting the operation.
- Counter saturates at all ones; it does not wrap.

Optional Feature:
- Macro RELAX_STATS_EN.
- Defined:
  - Counter of CNT_WIDTH bits is instantiated.
  - STATUS returns result[31:1]=counter (zero-extended to 31 bits) and result[0]=improved.
  - CLEAR zeroes the counter.
- Undefined:
  - No counter logic is built.
  - STATUS bits [31:1] read 0.

Test Plan:
1. Reset, then CLEAR; RELAX dataa=3F800000, datab=40000000 (ADD_LATENCY=2) -> done exactly at cycle start+4, result=40400000; then STATUS -> result=00000001 (with RELAX_STATS_EN: 00000003).
2. LOAD 40000000; RELAX 3F800000 + 40000000 -> result=40000000; STATUS bit0=0. Then RELAX 3F800000 + 3F000000 -> result=3FC00000.
3. CLEAR; RELAX datab=80000000, then datab=00000000, then dataa=7F800000 -> each gives done at start+1 with result=7F800000, and dist_v_reg stays INF_VALUE.
4. RELAX normal path with clk_en held low for 3 cycles mid-ADD_WAIT -> done at start+7, correct sum, done width exactly 1 cycle.
5. start pulsed again on cycle start+1 during a RELAX -> ignored: one done only, and result is from the first operation.
6. reset at cycle start+2 of a RELAX -> no done in the following 10 cycles; STATUS afterwards returns 00000000 and dist_v_reg reads INF_VALUE (verified via RELAX 3F800000 + 3F800000 returning 40000000).

Source files
------------

// File: rtl/dijkstra_relax_unit.sv
// dijkstra_relax_unit
//   Multi-cycle Nios II custom-instruction unit performing one Dijkstra edge
//   relaxation: candidate = dist_u + weight (IEEE-754 single), compared
//   against the held dist_v; the minimum is kept and returned.
//   Opcodes on n: 0 LOAD, 1 RELAX, 2 STATUS, 3 CLEAR.
//
//   Ports:
//     clk, reset     clock, synchronous active-high reset (overrides clk_en)
//     clk_en         freezes all state (adder pipeline included) when low
//     start, n       one-cycle operation strobe and opcode
//     dataa, datab   LOAD: new dist_v / RELAX: dist_u, edge weight
//     done, result   registered one-cycle completion pulse and result
//
//   Optional build macro RELAX_STATS_EN adds a saturating CNT_WIDTH-bit
//   relaxation counter reported by STATUS in result[31:1].

module fp_add #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [30:0] a,
  input  logic [30:0] b,
  output logic [30:0] sum
);
  // Magnitude add of two non-negative singles, round-to-nearest-even.
  // Overflow and INF/NaN inputs return +INF.
  function automatic logic [30:0] add_mag(input logic [30:0] x, input logic [30:0] y);
    logic [7:0]  ex, ey, eh, el, dif;
    logic [23:0] mh, ml;
    logic [26:0] ext, aligned, mask;
    logic [27:0] s;
    logic [8:0]  e;
    logic [24:0] r;
    logic        rnd;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return 31'h7F800000;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    if (ex >= ey) begin
      eh = ex; el = ey;
      mh = {x[30:23] != 8'd0, x[22:0]};
      ml = {y[30:23] != 8'd0, y[22:0]};
    end else begin
      eh = ey; el = ex;
      mh = {y[30:23] != 8'd0, y[22:0]};
      ml = {x[30:23] != 8'd0, x[22:0]};
    end
    dif = eh - el;
    ext = {ml, 3'b000};
    // Three extra bits (guard, round, sticky); shifted-out bits fold into sticky.
    if (dif > 8'd26) begin
      aligned = {26'd0, |ml};
    end else begin
      mask    = (27'd1 << dif) - 27'd1;
      aligned = (ext >> dif) | {26'd0, |(ext & mask)};
    end
    s = {1'b0, mh, 3'b000} + {1'b0, aligned};
    e = {1'b0, eh};
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 9'd1;
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    r   = {1'b0, s[26:3]} + {24'd0, rnd};
    if (r[24]) begin
      r = r >> 1;
      e = e + 9'd1;
    end
    if (e >= 9'd255) return 31'h7F800000;
    // Without a hidden bit the result is subnormal (exponent field 0).
    return {(r[23] ? e[7:0] : 8'd0), r[22:0]};
  endfunction

  logic [30:0] stage_d;
  logic [30:0] pipe_q [LATENCY];

  assign stage_d = add_mag(a, b);
  assign sum     = pipe_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= stage_d;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
endmodule

module dijkstra_relax_unit #(
  parameter int unsigned ADD_LATENCY = 2,
  parameter logic [31:0] INF_VALUE   = 32'h7F800000,
  parameter int unsigned CNT_WIDTH   = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        done,
  output logic [31:0] result
);
  if (ADD_LATENCY < 1 || ADD_LATENCY > 8) begin : g_bad_latency
    $error("ADD_LATENCY must be in 1..8");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 31) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be in 1..31");
  end

  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_STATUS = 2'd2, OP_CLEAR = 2'd3;
  localparam logic [3:0] WAIT_LAST = 4'(ADD_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [30:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] dist_v_q, dist_v_d;
  logic        improved_q, improved_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [30:0] sum;
  logic [31:0] cand;
  logic [30:0] status_hi;
  logic        fast_path, relax_done;
`ifdef RELAX_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  assign status_hi = 31'(cnt_q);
`else
  assign status_hi = '0;
`endif

  fp_add #(.LATENCY(ADD_LATENCY)) u_fp_add (
    .clk(clk), .reset(reset), .en(clk_en), .a(op_a_q), .b(op_b_q), .sum(sum)
  );

  // Operands for which the sum is INF or meaningless skip the adder.
  assign fast_path = (dataa[30:23] == 8'hFF) | (datab[30:23] == 8'hFF) |
                     datab[31] | (datab[30:0] == 31'd0);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    dist_v_d   = dist_v_q;
    improved_d = improved_q;
    done_d     = 1'b0;
    result_d   = result_q;
    relax_done = 1'b0;
    cand       = INF_VALUE;
`ifdef RELAX_STATS_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        op_a_d  = dataa[30:0];
        op_b_d  = datab[30:0];
        state_d = S_RESP;
        done_d  = 1'b1;
        case (n)
          OP_LOAD: begin
            dist_v_d = dataa;
            result_d = dataa;
          end
          OP_STATUS: result_d = {status_hi, improved_q};
          OP_CLEAR: begin
            dist_v_d   = INF_VALUE;
            improved_d = 1'b0;
            result_d   = '0;
`ifdef RELAX_STATS_EN
            cnt_d      = '0;
`endif
          end
          default: begin
            if (fast_path) begin
              relax_done = 1'b1;
            end else begin
              state_d    = S_WAIT;
              done_d     = 1'b0;
              wait_cnt_d = '0;
            end
          end
        endcase
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_RESP;
          done_d     = 1'b1;
          relax_done = 1'b1;
          cand       = (sum[30:23] == 8'hFF) ? INF_VALUE : {1'b0, sum};
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Both values are non-negative, so magnitude bits order them directly.
    if (relax_done) begin
      if (cand[30:0] < dist_v_q[30:0]) begin
        result_d   = cand;
        dist_v_d   = cand;
        improved_d = 1'b1;
      end else begin
        result_d   = dist_v_q;
        improved_d = 1'b0;
      end
`ifdef RELAX_STATS_EN
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      dist_v_q   <= INF_VALUE;
      improved_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
`ifdef RELAX_STATS_EN
      cnt_q      <= '0;
`endif
    end else if (clk_en) begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      dist_v_q   <= dist_v_d;
      improved_q <= improved_d;
      done_q     <= done_d;
      result_q   <= result_d;
`ifdef RELAX_STATS_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_dijkstra_relax_unit.sv
// Self-checking bench for dijkstra_relax_unit: directed scenarios plus
// randomized operations, checked against an exact-arithmetic float model.
module tb_dijkstra_relax_unit;
  localparam int unsigned L   = 2;
  localparam int unsigned CW  = 31;
  localparam logic [31:0] INF = 32'h7F800000;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_RELAX = 2'd1, OP_STATUS = 2'd2, OP_CLEAR = 2'd3;

  logic clk = 1'b0, reset, clk_en, start, done;
  logic [1:0]  n;
  logic [31:0] dataa, datab, result;

  dijkstra_relax_unit #(.ADD_LATENCY(L), .INF_VALUE(INF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, done_seen = 0;
  int          exp_cyc_q[$];
  logic [31:0] exp_res_q[$];
  string       name_q[$];

  // Model state
  logic [31:0] m_dist;
  logic        m_imp;
  longint      m_cnt;

  function automatic logic [299:0] units(input logic [31:0] x);
    logic [299:0] m;
    m = 300'(x[22:0]);
    if (x[30:23] == 8'd0) return m;
    m[23] = 1'b1;
    return m << (int'(x[30:23]) - 1);
  endfunction

  // Exact sum in units of 2^-149, then rounded to nearest even single.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [299:0] s, keep, rem, half;
    int p, sh;
    s = units(a) + units(b);
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    if (p <= 23) return {1'b0, s[30:0]};
    sh   = p - 23;
    keep = s >> sh;
    rem  = s - (keep << sh);
    half = 300'd1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
    if (keep[24]) begin keep = keep >> 1; sh++; end
    if (sh + 1 >= 255) return INF;
    return {1'b0, 8'(sh + 1), keep[22:0]};
  endfunction

  task automatic model_exec(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output int lat);
    logic [31:0] c;
    lat = 1;
    case (opc)
      OP_LOAD: begin m_dist = a; r = a; end
      OP_STATUS: begin
`ifdef RELAX_STATS_EN
        r = {m_cnt[30:0], m_imp};
`else
        r = {31'd0, m_imp};
`endif
      end
      OP_CLEAR: begin m_dist = INF; m_imp = 1'b0; m_cnt = 0; r = 32'd0; end
      default: begin
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || b[31] || b[30:0] == 31'd0) begin
          c = INF;
        end else begin
          c = ref_add(a, b);
          if (c[30:23] == 8'hFF) c = INF;
          lat = L + 2;
        end
        if (c[30:0] < m_dist[30:0]) begin r = c; m_dist = c; m_imp = 1'b1; end
        else begin r = m_dist; m_imp = 1'b0; end
        if (m_cnt < (64'd1 << CW) - 1) m_cnt++;
      end
    endcase
  endtask

  task automatic model_reset();
    m_dist = INF; m_imp = 1'b0; m_cnt = 0;
  endtask

  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] lit);
    checks++;
    if (got !== lit) begin
      errors++;
      $display("FAIL model_%s got %h expected %h", nm, got, lit);
    end
  endtask

  // Issue one operation (called #1 after a posedge, DUT idle); returns idle.
  task automatic op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                    input string nm, input bit use_lit, input logic [31:0] lit);
    logic [31:0] r;
    int lat;
    model_exec(opc, a, b, r, lat);
    if (use_lit) pin(nm, r, lit);
    exp_cyc_q.push_back(cyc + lat);
    exp_res_q.push_back(r);
    name_q.push_back(nm);
    start = 1'b1; n = opc; dataa = a; datab = b;
    @(posedge clk); #1;
    start = 1'b0; n = 2'($urandom); dataa = $urandom; datab = $urandom;
    repeat (lat) @(posedge clk);
    #1;
  endtask

  // Single compare process: every done must match the head expectation.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      checks++;
      if (exp_cyc_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_done cyc=%0d result=%h expected no done", cyc, result);
      end else begin
        if (exp_cyc_q[0] != cyc || result !== exp_res_q[0]) begin
          errors++;
          $display("FAIL done_%s cyc=%0d result=%h expected cyc=%0d result=%h",
                   name_q[0], cyc, result, exp_cyc_q[0], exp_res_q[0]);
        end
        void'(exp_cyc_q.pop_front()); void'(exp_res_q.pop_front()); void'(name_q.pop_front());
      end
    end else if (exp_cyc_q.size() != 0 && cyc >= exp_cyc_q[0]) begin
      checks++;
      errors++;
      $display("FAIL missing_done_%s cyc=%0d done=0 expected done with result=%h",
               name_q[0], cyc, exp_res_q[0]);
      void'(exp_cyc_q.pop_front()); void'(exp_res_q.pop_front()); void'(name_q.pop_front());
    end
  end

  function automatic logic [31:0] rand_pos();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) e = 8'd0;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'($urandom_range(240, 254));
    else e = 8'($urandom_range(110, 150));
    return {1'b0, e, 23'($urandom)};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, a, b;
    int lat, c, snap, k;
    logic [1:0] opc;
    reset = 1'b1; clk_en = 1'b0; start = 1'b1; n = OP_LOAD; dataa = 32'h12345678; datab = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h expected 00000000", result); end
    reset = 1'b0; clk_en = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    // 1: basic relax and status
    op(OP_CLEAR, '0, '0, "clear1", 1'b1, 32'h0);
    op(OP_RELAX, 32'h3F800000, 32'h40000000, "relax1", 1'b1, 32'h40400000);
`ifdef RELAX_STATS_EN
    op(OP_STATUS, '0, '0, "status1", 1'b1, 32'h00000003);
`else
    op(OP_STATUS, '0, '0, "status1", 1'b1, 32'h00000001);
`endif
    // 2: no improvement, then improvement
    op(OP_LOAD, 32'h40000000, '0, "load2", 1'b1, 32'h40000000);
    op(OP_RELAX, 32'h3F800000, 32'h40000000, "relax2a", 1'b1, 32'h40000000);
`ifdef RELAX_STATS_EN
    op(OP_STATUS, '0, '0, "status2", 1'b1, 32'h00000004);
`else
    op(OP_STATUS, '0, '0, "status2", 1'b1, 32'h00000000);
`endif
    op(OP_RELAX, 32'h3F800000, 32'h3F000000, "relax2b", 1'b1, 32'h3FC00000);
    // 3: fast paths keep INF
    op(OP_CLEAR, '0, '0, "clear3", 1'b1, 32'h0);
    op(OP_RELAX, 32'h3F800000, 32'h80000000, "fast_negzero", 1'b1, INF);
    op(OP_RELAX, 32'h3F800000, 32'h00000000, "fast_zero", 1'b1, INF);
    op(OP_RELAX, 32'h7F800000, 32'h3F800000, "fast_inf", 1'b1, INF);
    op(OP_RELAX, 32'h7F000000, 32'h7F000000, "overflow", 1'b1, INF);

    // 4: clk_en low for 3 cycles mid-wait
    model_exec(OP_RELAX, 32'h40000000, 32'h40400000, r, lat);
    pin("stall", r, 32'h40A00000);
    c = cyc;
    exp_cyc_q.push_back(c + 7); exp_res_q.push_back(r); name_q.push_back("stall");
    start = 1'b1; n = OP_RELAX; dataa = 32'h40000000; datab = 32'h40400000;
    @(posedge clk); #1;
    start = 1'b0; dataa = $urandom; datab = $urandom;
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1; clk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 5: second start during a RELAX is ignored
    model_exec(OP_RELAX, 32'h3F800000, 32'h3F800000, r, lat);
    pin("restart", r, 32'h40000000);
    c = cyc;
    exp_cyc_q.push_back(c + L + 2); exp_res_q.push_back(r); name_q.push_back("restart");
    start = 1'b1; n = OP_RELAX; dataa = 32'h3F800000; datab = 32'h3F800000;
    @(posedge clk); #1;
    n = OP_LOAD; dataa = 32'h00000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (L + 1) @(posedge clk);
    #1;

    // 6: reset mid-RELAX aborts without done
    op(OP_LOAD, 32'h3F000000, '0, "load6", 1'b0, '0);
    start = 1'b1; n = OP_RELAX; dataa = 32'h3F800000; datab = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    snap = done_seen;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_seen != snap) begin
      errors++;
      $display("FAIL abort_no_done got %0d dones expected 0", done_seen - snap);
    end
    op(OP_STATUS, '0, '0, "status6", 1'b1, 32'h0);
    op(OP_RELAX, 32'h3F800000, 32'h3F800000, "relax6", 1'b1, 32'h40000000);

    // Randomized operation mix
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 19);
      if (k < 12) opc = OP_RELAX;
      else if (k < 15) opc = OP_LOAD;
      else if (k < 18) opc = OP_STATUS;
      else opc = OP_CLEAR;
      a = rand_pos();
      b = rand_pos();
      k = $urandom_range(0, 14);
      if (k == 0) b[31] = 1'b1;
      else if (k == 1) b = 32'd0;
      op(opc, a, b, "rand", 1'b0, '0);
    end

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d expected 0", exp_cyc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
